// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 Set-2 key event path.
package ps2_kbd_pkg;

  // Framing state of the scan-code assembler.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } frame_state_t;

  // Prefix and protocol bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FE = 8'hFE;

  // Mapped key codes
  localparam logic [7:0] KC_W     = 8'h1D;
  localparam logic [7:0] KC_S     = 8'h1B;
  localparam logic [7:0] KC_UP    = 8'h75;
  localparam logic [7:0] KC_DOWN  = 8'h72;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] KC_R     = 8'h2D;
  localparam logic [7:0] KC_ENTER = 8'h5A;
  localparam logic [7:0] KC_ESC   = 8'h76;

  // key_held bit positions
  localparam int HB_W     = 7;
  localparam int HB_S     = 6;
  localparam int HB_UP    = 5;
  localparam int HB_DOWN  = 4;
  localparam int HB_SPACE = 3;
  localparam int HB_R     = 2;
  localparam int HB_ENTER = 1;
  localparam int HB_ESC   = 0;

  // Bytes that never form or continue a key event (BAT result, ack, resend, pause, errors).
  function automatic logic is_non_event(input logic [7:0] code);
    return (code == SC_E1) || (code == SC_AA) || (code == SC_FA) ||
           (code == SC_FE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational (ext, code) to one-hot key_held bit decode.
module ps2_key_map
  import ps2_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic [7:0] match
);

  // One bit per mapped key; the ext flag must agree with the key's definition.
  always_comb begin
    match            = '0;
    match[HB_W]      = !ext && (code == KC_W);
    match[HB_S]      = !ext && (code == KC_S);
    match[HB_UP]     =  ext && (code == KC_UP);
    match[HB_DOWN]   =  ext && (code == KC_DOWN);
    match[HB_SPACE]  = !ext && (code == KC_SPACE);
    match[HB_R]      = !ext && (code == KC_R);
    match[HB_ENTER]  = !ext && (code == KC_ENTER);
    match[HB_ESC]    = !ext && (code == KC_ESC);
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 receiver gating, scan-code framing into key events, and held-key tracking.
//
//   state      | meaning
//   -----------+-------------------------------------------
//   ST_IDLE    | no prefix pending
//   ST_EXT     | E0 seen, waiting for code (or F0)
//   ST_BRK     | F0 seen, waiting for code (or E0)
//   ST_EXT_BRK | E0 and F0 seen, waiting for code
module ps2_key_event_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int RX_GUARD       = 1000,
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       rx_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic [7:0] key_held,
  output logic       frame_error
);

  localparam int GW = (RX_GUARD < 1) ? 1 : $clog2(RX_GUARD + 1);
  localparam int WW = (PREFIX_TIMEOUT < 1) ? 1 : $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [GW-1:0] GUARD_TC = GW'(RX_GUARD);
  localparam logic [WW-1:0] WD_TC    = WW'(PREFIX_TIMEOUT);

  frame_state_t   state, state_nxt;
  logic [GW-1:0]  guard_cnt;
  logic [WW-1:0]  wd_cnt;
  logic           byte_acc;
  logic           wd_expire;
  logic           pre_ext, pre_rel;
  logic           ev_fire, ev_ext, ev_rel;
  logic [7:0]     key_match;

  // Guard counter: saturates at the terminal count, which opens the receiver.
  always_ff @(posedge clk) begin
    if (reset)
      guard_cnt <= '0;
    else if (guard_cnt != GUARD_TC)
      guard_cnt <= guard_cnt + GW'(1);
  end

  assign rx_en    = (guard_cnt == GUARD_TC);
  assign byte_acc = scan_valid && rx_en;

  // An accepted byte always beats the watchdog on the same cycle.
  assign wd_expire = (state != ST_IDLE) && !byte_acc && (wd_cnt == WD_TC);

  // Prefix watchdog: runs only while a prefix is pending.
  always_ff @(posedge clk) begin
    if (reset)
      wd_cnt <= '0;
    else if (byte_acc || (state == ST_IDLE) || wd_expire)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WW'(1);
  end

  // Framing state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and event decode.
  always_comb begin
    state_nxt = state;
    ev_fire   = 1'b0;
    ev_ext    = 1'b0;
    ev_rel    = 1'b0;
    pre_ext   = 1'b0;
    pre_rel   = 1'b0;
    case (state)
      ST_IDLE:    begin pre_ext = 1'b0; pre_rel = 1'b0; end
      ST_EXT:     begin pre_ext = 1'b1; pre_rel = 1'b0; end
      ST_BRK:     begin pre_ext = 1'b0; pre_rel = 1'b1; end
      ST_EXT_BRK: begin pre_ext = 1'b1; pre_rel = 1'b1; end
      default:    begin pre_ext = 1'b0; pre_rel = 1'b0; end
    endcase
    if (byte_acc) begin
      if (scan_code == SC_E0) begin
        state_nxt = pre_rel ? ST_EXT_BRK : ST_EXT;
      end else if (scan_code == SC_F0) begin
        state_nxt = pre_ext ? ST_EXT_BRK : ST_BRK;
      end else if (is_non_event(scan_code)) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_IDLE;
        ev_fire   = 1'b1;
        ev_ext    = pre_ext;
        ev_rel    = pre_rel;
      end
    end else if (wd_expire) begin
      state_nxt = ST_IDLE;
    end
  end

  ps2_key_map u_key_map (
    .ext   (ev_ext),
    .code  (scan_code),
    .match (key_match)
  );

  // Registered event outputs and held-key vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 8'h00;
      frame_error <= 1'b0;
    end else begin
      key_valid   <= ev_fire;
      frame_error <= wd_expire;
      if (ev_fire) begin
        key_code    <= scan_code;
        key_ext     <= ev_ext;
        key_release <= ev_rel;
        if (ev_rel)
          key_held <= key_held & ~key_match;
        else
          key_held <= key_held | key_match;
      end
    end
  end

endmodule
